// File: rtl/cpu_instruction_fetch.sv
// Instruction fetch unit: issues one outstanding word fetch at a time, queues
// returned instructions with their PC in a small FIFO for decode, and handles
// branch/jump redirects by flushing the queue and discarding stale responses.
module cpu_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] output_address,
  output logic [31:0] output_instruction,
  output logic        output_valid,
  input  logic        output_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [31:0]     buf_pc  [DEPTH];
  logic [31:0]     buf_ins [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic issue, push, pop;

  // Redirect wins over everything; a request only issues when a slot is free
  // without crediting a same-cycle pop, so the FIFO can never overflow.
  assign issue = (state == S_RUN) && (count < CW'(DEPTH)) && !redirect_valid;
  assign push  = (state == S_WAIT) && imem_ack && !redirect_valid;
  assign pop   = (count != '0) && !output_full && !redirect_valid;

  // Next-state logic; a response arriving alongside a redirect is simply
  // dropped, and since it retires the outstanding request we go to RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (issue) state_nxt = S_WAIT;
      S_WAIT:  if (imem_ack) state_nxt = S_RUN;
               else if (redirect_valid) state_nxt = S_DROP;
      S_DROP:  if (imem_ack) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // Request and head outputs are pure functions of registered state.
  always_comb begin
    imem_req           = (state == S_WAIT);
    imem_addr          = pc;
    output_valid       = (count != '0);
    output_address     = buf_pc[rd_ptr];
    output_instruction = buf_ins[rd_ptr];
  end

  // State register and fetch PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid)
        pc <= redirect_target & ~32'h3;
      else if (push)
        pc <= pc + 32'd4;
    end
  end

  // Instruction FIFO; a redirect empties it and cancels any push/pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]  <= '0;
        buf_ins[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]  <= pc;
        buf_ins[wr_ptr] <= imem_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_cpu_instruction_fetch.sv
// Directed bench for cpu_instruction_fetch: a latency-configurable memory
// model, or hand-driven acks, plus monitors logging issued fetch addresses
// and instructions consumed by decode.
module tb_cpu_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] output_address;
  logic [31:0] output_instruction;
  logic        output_valid;
  logic        output_full = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // memory model / manual drive
  bit          mem_en = 1'b0;
  int          lat = 1;
  logic        m_ack = 1'b0, man_ack = 1'b0;
  logic [31:0] m_data = '0, man_data = '0, m_addr = '0;
  bit          m_busy = 1'b0;
  int          m_rem = 0;

  logic [63:0] pop_q[$];
  logic [31:0] req_q[$];
  bit          logged = 1'b0;

  assign imem_ack  = mem_en ? m_ack  : man_ack;
  assign imem_data = mem_en ? m_data : man_data;

  cpu_instruction_fetch dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .output_address(output_address), .output_instruction(output_instruction),
    .output_valid(output_valid), .output_full(output_full)
  );

  always #5 clock = ~clock;

  // Memory returns ~addr after 'lat' cycles (lat=1: same cycle req is seen).
  always @(posedge clock) begin
    #1;
    m_ack = 1'b0;
    if (!reset || !mem_en) m_busy = 1'b0;
    else if (m_busy) begin
      m_rem--;
      if (m_rem <= 0) begin m_ack = 1'b1; m_data = ~m_addr; m_busy = 1'b0; end
    end else if (imem_req) begin
      m_addr = imem_addr;
      m_rem  = lat - 1;
      if (m_rem <= 0) begin m_ack = 1'b1; m_data = ~m_addr; end
      else m_busy = 1'b1;
    end
  end

  // Log each issued request once, and every instruction accepted by decode.
  always @(negedge clock) begin
    if (reset) begin
      if (output_valid && !output_full && !redirect_valid)
        pop_q.push_back({output_address, output_instruction});
      if (imem_req && !logged) begin req_q.push_back(imem_addr); logged = 1'b1; end
      if (imem_ack || !imem_req) logged = 1'b0;
    end else logged = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] popat(input int i);
    return (i < pop_q.size()) ? pop_q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [31:0] reqat(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold reset a few cycles, then release just after an edge.
  task automatic do_reset(input bit full, input bit en, input int l);
    reset = 1'b0; redirect_valid = 1'b0; man_ack = 1'b0;
    output_full = full; mem_en = en; lat = l;
    tick(3);
    pop_q.delete(); req_q.delete();
    reset = 1'b1;
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_req",   {63'd0, imem_req},     64'd0);
    chk("rst_addr",  {32'd0, imem_addr},    64'hBFC0_0000);
    chk("rst_valid", {63'd0, output_valid}, 64'd0);
    chk("rst_oaddr", {32'd0, output_address},     64'd0);
    chk("rst_oinst", {32'd0, output_instruction}, 64'd0);

    // streaming with 1-cycle memory
    do_reset(1'b0, 1'b1, 1);
    tick(10);
    chk("seq_nreq", req_q.size(), 5);
    chk("seq_npop", pop_q.size(), 4);
    chk("seq_req0", {32'd0, reqat(0)}, 64'hBFC0_0000);
    chk("seq_req1", {32'd0, reqat(1)}, 64'hBFC0_0004);
    chk("seq_req2", {32'd0, reqat(2)}, 64'hBFC0_0008);
    chk("seq_pop0", popat(0), {32'hBFC0_0000, 32'h403F_FFFF});
    chk("seq_pop1", popat(1), {32'hBFC0_0004, 32'h403F_FFFB});
    chk("seq_pop2", popat(2), {32'hBFC0_0008, 32'h403F_FFF7});

    // backpressure fills exactly DEPTH entries, then drains in order
    do_reset(1'b1, 1'b1, 1);
    tick(12);
    chk("bp_nreq",  req_q.size(), 2);
    chk("bp_req",   {63'd0, imem_req},     64'd0);
    chk("bp_valid", {63'd0, output_valid}, 64'd1);
    chk("bp_head",  {output_address, output_instruction}, {32'hBFC0_0000, 32'h403F_FFFF});
    output_full = 1'b0;
    tick(10);
    chk("bp_pop0", popat(0), {32'hBFC0_0000, 32'h403F_FFFF});
    chk("bp_pop1", popat(1), {32'hBFC0_0004, 32'h403F_FFFB});
    chk("bp_req2", {32'd0, reqat(2)}, 64'hBFC0_0008);

    // redirect while waiting, stale ack 3 cycles later
    do_reset(1'b0, 1'b0, 1);
    tick(1);
    redirect_valid = 1'b1; redirect_target = 32'h0040_0003;
    tick(1);
    redirect_valid = 1'b0;
    chk("drop_req",   {63'd0, imem_req},  64'd0);
    chk("drop_addr",  {32'd0, imem_addr}, 64'h0040_0000);
    chk("drop_valid", {63'd0, output_valid}, 64'd0);
    tick(2);
    man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
    tick(1);
    man_ack = 1'b0;
    chk("drop_valid2", {63'd0, output_valid}, 64'd0);
    chk("drop_req2",   {63'd0, imem_req},     64'd0);
    tick(1);
    chk("drop_req3",  {63'd0, imem_req},  64'd1);
    chk("drop_addr3", {32'd0, imem_addr}, 64'h0040_0000);
    chk("drop_valid3", {63'd0, output_valid}, 64'd0);
    man_ack = 1'b1; man_data = 32'h1234_5678;
    tick(1);
    man_ack = 1'b0;
    chk("drop_head", {31'd0, output_valid, output_address}, {31'd0, 1'b1, 32'h0040_0000});
    chk("drop_inst", {32'd0, output_instruction}, 64'h1234_5678);

    // redirect coincident with ack and a would-be pop
    do_reset(1'b1, 1'b0, 1);
    tick(1);
    man_ack = 1'b1; man_data = 32'h1111_1111;
    tick(1);
    man_ack = 1'b0;
    tick(1);
    chk("co_req",   {32'd0, imem_req, imem_addr[30:0]}, {32'd0, 1'b1, 31'h3FC0_0004});
    tick(1);
    output_full = 1'b0; man_ack = 1'b1; man_data = 32'h2222_2222;
    redirect_valid = 1'b1; redirect_target = 32'h0000_1000;
    tick(1);
    man_ack = 1'b0; redirect_valid = 1'b0;
    chk("co_valid", {63'd0, output_valid}, 64'd0);
    chk("co_req2",  {63'd0, imem_req},     64'd0);
    tick(1);
    chk("co_req3",  {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0000_1000});
    man_ack = 1'b1; man_data = 32'h3333_3333;
    tick(1);
    man_ack = 1'b0;
    chk("co_head",  {output_address, output_instruction}, {32'h0000_1000, 32'h3333_3333});

    // redirect while buffer full with pop in same cycle
    do_reset(1'b1, 1'b1, 1);
    tick(10);
    chk("fr_full", {62'd0, output_valid, imem_req}, {62'd0, 2'b10});
    output_full = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_2000;
    tick(1);
    redirect_valid = 1'b0;
    chk("fr_empty", {62'd0, output_valid, imem_req}, {62'd0, 2'b00});
    tick(1);
    chk("fr_req",   {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0000_2000});
    tick(1);
    chk("fr_head",  {output_address, output_instruction}, {32'h0000_2000, 32'hFFFF_DFFF});

    // PC wraps past the top of the address space
    do_reset(1'b0, 1'b1, 1);
    tick(4);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    pop_q.delete(); req_q.delete();
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    chk("wrap_req0", {32'd0, reqat(0)}, 64'hFFFF_FFFC);
    chk("wrap_req1", {32'd0, reqat(1)}, 64'h0000_0000);
    chk("wrap_pop0", popat(0), {32'hFFFF_FFFC, 32'h0000_0003});
    chk("wrap_pop1", popat(1), {32'h0000_0000, 32'hFFFF_FFFF});

    // reset mid-wait; ack right after release is ignored
    do_reset(1'b0, 1'b0, 1);
    tick(1);
    chk("rw_req", {63'd0, imem_req}, 64'd1);
    reset = 1'b0;
    #2;
    chk("rw_async", {63'd0, imem_req}, 64'd0);
    tick(2);
    reset = 1'b1; man_ack = 1'b1; man_data = 32'hBAD0_BAD0;
    tick(1);
    man_ack = 1'b0;
    chk("rw_req2",   {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'hBFC0_0000});
    chk("rw_valid",  {63'd0, output_valid}, 64'd0);
    tick(1);
    chk("rw_valid2", {62'd0, output_valid, imem_req}, {62'd0, 2'b01});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
